// File: rtl/traffic_phase_fsm.sv
// ---------------------------------------------------------------------------
// traffic_phase_fsm
//
// Phase sequencer for a two-road (NS/EW) intersection. It sits downstream of
// the configurable phase timer: each signal_change pulse from the timer means
// the current timed phase has expired. Whenever a phase is entered, or a
// green phase is re-armed for another timer period, the sequencer sends the
// timer a one-cycle timer_trigger pulse so the timer starts counting again.
// Pedestrian requests are latched until the walk phase serves them. The
// emergency input forces all-red and overrides everything else.
//
// Parameters
//   GREEN_PERIODS  timer expiries spent in each green phase (>= 1)
//   PERIOD_W       width of the green period counter
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   signal_change     in   1-cycle pulse from the timer: current phase expired
//   emergency         in   level; forces all-red while high
//   ped_request       in   any high sample sets the pending walk request
//   timer_trigger     out  registered 1-cycle pulse: (re)start the timer
//   ns_light          out  00=RED 01=YELLOW 10=GREEN
//   ew_light          out  same encoding as ns_light
//   ped_walk          out  high only during the pedestrian walk phase
//   emergency_active  out  high only during the emergency phase
// ---------------------------------------------------------------------------
module traffic_phase_fsm #(
    parameter int GREEN_PERIODS = 2,
    parameter int PERIOD_W      = $clog2(GREEN_PERIODS + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_change,
    input  logic       emergency,
    input  logic       ped_request,
    output logic       timer_trigger,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic       emergency_active
);

    typedef enum logic [2:0] {
        ALL_RED_B = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_A = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        EMERG     = 3'd7
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [PERIOD_W-1:0] LAST_PERIOD = PERIOD_W'(GREEN_PERIODS - 1);
    localparam logic [PERIOD_W-1:0] ONE_PERIOD  = PERIOD_W'(1);

    state_t              state;
    logic                ped_pending;
    logic [PERIOD_W-1:0] green_cnt;
    logic                start_flag;

    // Output pattern {ns_light, ew_light, ped_walk, emergency_active} for the
    // state being entered, so every output is registered together with the
    // state and changes on the very edge the state changes.
    function automatic logic [5:0] outputs_for(input state_t s);
        case (s)
            NS_GREEN:  return {GREEN,  RED,    2'b00};
            NS_YELLOW: return {YELLOW, RED,    2'b00};
            EW_GREEN:  return {RED,    GREEN,  2'b00};
            EW_YELLOW: return {RED,    YELLOW, 2'b00};
            PED_WALK:  return {RED,    RED,    2'b10};
            EMERG:     return {RED,    RED,    2'b01};
            default:   return {RED,    RED,    2'b00};
        endcase
    endfunction

    // Whole sequencer in one clocked block. Priority from highest to lowest:
    // emergency, leaving emergency, the post-reset start pulse, then a timer
    // expiry. timer_trigger defaults low each cycle so it can only ever be a
    // single-cycle pulse. A pedestrian request is latched first; the clear on
    // walk entry is written afterwards but reloads ped_request, so a request
    // arriving on that same edge still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ALL_RED_B;
            ns_light         <= RED;
            ew_light         <= RED;
            ped_walk         <= 1'b0;
            emergency_active <= 1'b0;
            timer_trigger    <= 1'b0;
            ped_pending      <= 1'b0;
            green_cnt        <= '0;
            start_flag       <= 1'b1;
        end else begin
            timer_trigger <= 1'b0;
            if (ped_request) begin
                ped_pending <= 1'b1;
            end

            if (emergency) begin
                // No trigger on entry; the timer is held by emergency itself.
                // The start pulse is dropped because the exit pulse restarts
                // the timer anyway.
                if (state != EMERG) begin
                    state <= EMERG;
                    {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(EMERG);
                    green_cnt  <= '0;
                    start_flag <= 1'b0;
                end
            end else if (state == EMERG) begin
                state <= ALL_RED_B;
                {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(ALL_RED_B);
                green_cnt     <= '0;
                timer_trigger <= 1'b1;
            end else if (start_flag) begin
                timer_trigger <= 1'b1;
                start_flag    <= 1'b0;
            end else if (signal_change) begin
                case (state)
                    NS_GREEN: begin
                        if (green_cnt == LAST_PERIOD) begin
                            state <= NS_YELLOW;
                            {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(NS_YELLOW);
                            green_cnt <= '0;
                        end else begin
                            green_cnt <= green_cnt + ONE_PERIOD;
                        end
                        timer_trigger <= 1'b1;
                    end
                    NS_YELLOW: begin
                        state <= ALL_RED_A;
                        {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(ALL_RED_A);
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                    ALL_RED_A: begin
                        state <= EW_GREEN;
                        {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(EW_GREEN);
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                    EW_GREEN: begin
                        if (green_cnt == LAST_PERIOD) begin
                            state <= EW_YELLOW;
                            {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(EW_YELLOW);
                            green_cnt <= '0;
                        end else begin
                            green_cnt <= green_cnt + ONE_PERIOD;
                        end
                        timer_trigger <= 1'b1;
                    end
                    EW_YELLOW: begin
                        state <= ALL_RED_B;
                        {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(ALL_RED_B);
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                    ALL_RED_B: begin
                        if (ped_pending) begin
                            state <= PED_WALK;
                            {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(PED_WALK);
                            ped_pending <= ped_request;
                        end else begin
                            state <= NS_GREEN;
                            {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(NS_GREEN);
                        end
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                    PED_WALK: begin
                        state <= NS_GREEN;
                        {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(NS_GREEN);
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                    default: begin
                        state <= ALL_RED_B;
                        {ns_light, ew_light, ped_walk, emergency_active} <= outputs_for(ALL_RED_B);
                        green_cnt     <= '0;
                        timer_trigger <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_fsm
//
// Bench for traffic_phase_fsm. A small timer model (CLOCK_TIME=4) answers
// every timer_trigger with a signal_change pulse. A reference model steps
// through the phase rotation as an index into a six-entry cycle plus walk and
// emergency flags, and every scenario task compares the DUT outputs with it
// on the falling clock edge, alongside directed checks of the key behaviours.
// ---------------------------------------------------------------------------
module tb_traffic_phase_fsm;

    localparam int GREEN_PERIODS = 2;
    localparam int CLOCK_TIME    = 4;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       signal_change;
    logic       emergency = 1'b0;
    logic       ped_request = 1'b0;
    logic       timer_trigger;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic       emergency_active;

    int checks_total  = 0;
    int checks_passed = 0;

    traffic_phase_fsm #(
        .GREEN_PERIODS(GREEN_PERIODS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .signal_change    (signal_change),
        .emergency        (emergency),
        .ped_request      (ped_request),
        .timer_trigger    (timer_trigger),
        .ns_light         (ns_light),
        .ew_light         (ew_light),
        .ped_walk         (ped_walk),
        .emergency_active (emergency_active)
    );

    always #5 clk = ~clk;

    logic [6:0] dut_out;
    assign dut_out = {timer_trigger, ns_light, ew_light, ped_walk, emergency_active};

    // Timer model: a trigger loads CLOCK_TIME, and the pulse appears when the
    // count runs out. Updated on the falling edge so the DUT samples it stably.
    logic [2:0] tcnt;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt          <= 3'd0;
            signal_change <= 1'b0;
        end else if (timer_trigger) begin
            tcnt          <= 3'(CLOCK_TIME);
            signal_change <= 1'b0;
        end else if (tcnt != 3'd0) begin
            tcnt          <= tcnt - 3'd1;
            signal_change <= (tcnt == 3'd1);
        end else begin
            signal_change <= 1'b0;
        end
    end

    // Reference model. phase indexes the rotation
    // 0 NS green, 1 NS yellow, 2 all red, 3 EW green, 4 EW yellow, 5 all red;
    // walk and emerg are overlays on top of that rotation.
    typedef struct packed {
        logic       start;
        logic       emerg;
        logic       walk;
        logic [2:0] phase;
        logic [7:0] cnt;
        logic       ped;
        logic       trig;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r       = '0;
        r.start = 1'b1;
        r.phase = 3'd5;
        return r;
    endfunction

    function automatic model_t model_step(model_t cur, logic e, logic s, logic p);
        model_t n;
        n      = cur;
        n.trig = 1'b0;
        n.ped  = cur.ped | p;
        if (e) begin
            if (!cur.emerg) begin
                n.emerg = 1'b1;
                n.walk  = 1'b0;
                n.cnt   = 8'd0;
                n.start = 1'b0;
            end
        end else if (cur.emerg) begin
            n.emerg = 1'b0;
            n.phase = 3'd5;
            n.cnt   = 8'd0;
            n.trig  = 1'b1;
        end else if (cur.start) begin
            n.start = 1'b0;
            n.trig  = 1'b1;
        end else if (s) begin
            n.trig = 1'b1;
            if (cur.walk) begin
                n.walk  = 1'b0;
                n.phase = 3'd0;
            end else if ((cur.phase == 3'd0 || cur.phase == 3'd3) &&
                         (int'(cur.cnt) + 1 < GREEN_PERIODS)) begin
                n.cnt = cur.cnt + 8'd1;
            end else if (cur.phase == 3'd5 && cur.ped) begin
                n.walk = 1'b1;
                n.ped  = p;
            end else begin
                n.phase = (cur.phase == 3'd5) ? 3'd0 : cur.phase + 3'd1;
                n.cnt   = 8'd0;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] model_out(model_t cur);
        logic [1:0] ns;
        logic [1:0] ew;
        ns = RED;
        ew = RED;
        if (cur.emerg) return {cur.trig, 4'b0000, 2'b01};
        if (cur.walk)  return {cur.trig, 4'b0000, 2'b10};
        case (cur.phase)
            3'd0:    ns = GREEN;
            3'd1:    ns = YELLOW;
            3'd3:    ew = GREEN;
            3'd4:    ew = YELLOW;
            default: ;
        endcase
        return {cur.trig, ns, ew, 2'b00};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, emergency, signal_change, ped_request);
    end

    logic [6:0] exp_out;
    assign exp_out = model_out(m);

    task automatic test_reset();
        logic found;
        #1 rst_n = 1'b0;
        #1;
        checks_total++;
        if (dut_out !== 7'b0) $display("[TB] FAIL reset_async got=%b exp=%b", dut_out, 7'b0);
        else checks_passed++;
        repeat (3) @(negedge clk);
        checks_total++;
        if (dut_out !== 7'b0) $display("[TB] FAIL reset_hold got=%b exp=%b", dut_out, 7'b0);
        else checks_passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({timer_trigger, ns_light, ew_light} !== 5'b10000)
            $display("[TB] FAIL start_trigger got=%b exp=%b", {timer_trigger, ns_light, ew_light}, 5'b10000);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if (timer_trigger !== 1'b0) $display("[TB] FAIL start_single got=%b exp=0", timer_trigger);
        else checks_passed++;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_reset got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ns_light == GREEN) begin
                found = 1'b1;
                break;
            end
        end
        checks_total++;
        if (!found || ew_light !== RED || timer_trigger !== 1'b1)
            $display("[TB] FAIL first_ns_green got=%b/%b/%b exp=10/00/1", ns_light, ew_light, timer_trigger);
        else checks_passed++;
    endtask

    task automatic test_rotation();
        int  ns_len = 0, ns_trig = 0, ew_len = 0, ew_trig = 0;
        logic ns_fresh = 1'b0;
        logic done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_rotation got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ew_light == GREEN) begin
                ew_len++;
                if (timer_trigger) ew_trig++;
            end
            if (ns_light != GREEN && ns_fresh && ns_len > 0) begin
                done = 1'b1;
                break;
            end
            if (ns_light != GREEN) ns_fresh = 1'b1;
            if (ns_light == GREEN && ns_fresh) begin
                ns_len++;
                if (timer_trigger) ns_trig++;
            end
        end
        checks_total++;
        if (!done) $display("[TB] FAIL rotation_timeout got=0 exp=1");
        else checks_passed++;
        checks_total++;
        if (ew_len != 10 || ew_trig != 2)
            $display("[TB] FAIL ew_green_len got=%0d/%0d exp=10/2", ew_len, ew_trig);
        else checks_passed++;
        checks_total++;
        if (ns_len != 10 || ns_trig != 2)
            $display("[TB] FAIL ns_green_len got=%0d/%0d exp=10/2", ns_len, ns_trig);
        else checks_passed++;
    endtask

    task automatic test_ped_walk();
        logic found = 1'b0;
        int   walk_len = 0;
        int   stray_walk = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_ped_wait got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            found = (ew_light == GREEN);
        end
        #1 ped_request = 1'b1;
        @(negedge clk);
        #1 ped_request = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_ped got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ped_walk) begin
                walk_len++;
                if (ns_light !== RED || ew_light !== RED)
                    $display("[TB] FAIL walk_lights got=%b/%b exp=00/00", ns_light, ew_light);
            end else if (walk_len > 0) begin
                found = 1'b1;
                break;
            end
        end
        checks_total++;
        if (!found || walk_len != 5 || ns_light !== GREEN)
            $display("[TB] FAIL ped_walk_period got=%0d/%b exp=5/10", walk_len, ns_light);
        else checks_passed++;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_ped_after got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ped_walk) stray_walk++;
        end
        checks_total++;
        if (stray_walk != 0) $display("[TB] FAIL ped_cleared got=%0d exp=0", stray_walk);
        else checks_passed++;
    endtask

    task automatic test_ped_same_cycle();
        logic found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = (ew_light == GREEN);
        end
        #1 ped_request = 1'b1;
        @(negedge clk);
        #1 ped_request = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (ew_light == YELLOW);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (ew_light == RED);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_same got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            #1;
            if (signal_change) begin
                ped_request = 1'b1;
                found = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks_total++;
        if (!found || ped_walk !== 1'b1 || timer_trigger !== 1'b1)
            $display("[TB] FAIL walk_entry got=%b/%b exp=1/1", ped_walk, timer_trigger);
        else checks_passed++;
        #1 ped_request = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_repeat got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ped_walk && timer_trigger && i > 5) begin
                found = 1'b1;
                break;
            end
        end
        checks_total++;
        if (!found) $display("[TB] FAIL walk_repeat got=0 exp=1");
        else checks_passed++;
    endtask

    task automatic test_emergency();
        logic found = 1'b0;
        int   hold;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_em_wait got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            #1;
            if (ns_light == GREEN && signal_change) begin
                emergency = 1'b1;
                found = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks_total++;
        if (!found || dut_out !== 7'b0000001)
            $display("[TB] FAIL emerg_entry got=%b exp=%b", dut_out, 7'b0000001);
        else checks_passed++;
        hold = int'($urandom_range(2, 5));
        for (int i = 0; i < hold; i++) begin
            #1 ped_request = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_emerg got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
        end
        #1;
        emergency   = 1'b0;
        ped_request = 1'b0;
        @(negedge clk);
        checks_total++;
        if (dut_out !== 7'b1000000) $display("[TB] FAIL emerg_exit got=%b exp=%b", dut_out, 7'b1000000);
        else checks_passed++;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_resume got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
        end
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_random got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            #1;
            if (burst > 0) burst--;
            else if ($urandom_range(0, 39) == 0) burst = int'($urandom_range(1, 6));
            emergency   = (burst > 0);
            ped_request = ($urandom_range(0, 9) == 0);
        end
        #1;
        emergency   = 1'b0;
        ped_request = 1'b0;
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_pre_rst got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
            if (ew_light == YELLOW) begin
                found = 1'b1;
                break;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks_total++;
        if (!found || dut_out !== 7'b0)
            $display("[TB] FAIL async_reset got=%b exp=%b", dut_out, 7'b0);
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks_total++;
            if (dut_out !== exp_out) $display("[TB] FAIL model_post_rst got=%b exp=%b", dut_out, exp_out);
            else checks_passed++;
        end
    endtask

    initial begin
        $display("[TB] traffic_phase_fsm bench start");
        test_reset();
        test_rotation();
        test_ped_walk();
        test_ped_same_cycle();
        test_emergency();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
